// File: rtl/gpio_cfg_pkg.sv
// Shared types and constants for the GPIO pad-configuration sequencer.
package gpio_cfg_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    SHIFT = 3'd2,
    LOAD  = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam int CLEAR_CYCLES          = 2;
  localparam int GPIO_CFG_BITS_DEFAULT = 13;
  localparam int CLEAR_CNT_W           = 1;

  // Width of the bit-index counter for an n-bit chain (at least one bit).
  function automatic int bit_cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/gpio_cfg_serializer.sv
// Shadow copy of the configuration vector plus the bit index / phase walker
// that selects the next chain bit, MSB first.
module gpio_cfg_serializer
  import gpio_cfg_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic         step_i,
  input  logic [N-1:0] data_i,
  output logic         bit_out_o,
  output logic         phase_o,
  output logic         last_o
);

  localparam int CW = bit_cnt_width(N);

  logic [N-1:0]  shadow_q, shadow_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          phase_q, phase_d;

  // cnt/phase describe the chain position to be presented on the next cycle;
  // the walker parks on (bit 0, phase B) so last_o stays up until the FSM leaves.
  always_comb begin
    shadow_d = shadow_q;
    cnt_d    = cnt_q;
    phase_d  = phase_q;
    if (load_i) begin
      shadow_d = data_i;
      cnt_d    = CW'(N - 1);
      phase_d  = 1'b0;
    end else if (step_i && !last_o) begin
      phase_d = ~phase_q;
      if (phase_q) begin
        cnt_d = cnt_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      shadow_q <= '0;
      cnt_q    <= '0;
      phase_q  <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      cnt_q    <= cnt_d;
      phase_q  <= phase_d;
    end
  end

  assign bit_out_o = shadow_q[cnt_q];
  assign phase_o   = phase_q;
  assign last_o    = phase_q && (cnt_q == '0);

endmodule

// File: rtl/gpio_cfg_sequencer.sv
// Sequencer that clears the GPIO pad control chain, shifts the captured
// default words into it and pulses the latch strobe; all outputs registered.
module gpio_cfg_sequencer
  import gpio_cfg_pkg::*;
#(
  parameter int NUM_PADS = 19,
  parameter int CFG_BITS = GPIO_CFG_BITS_DEFAULT
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         start,
  input  logic [NUM_PADS*CFG_BITS-1:0] cfg_data,
  output logic                         serial_clock,
  output logic                         serial_data_out,
  output logic                         serial_load,
  output logic                         serial_resetn,
  output logic                         busy,
  output logic                         done,
  output state_t                       dbg_state
);

  localparam int N = NUM_PADS * CFG_BITS;

  state_t                 state_q, state_d;
  logic [CLEAR_CNT_W-1:0] clr_cnt_q, clr_cnt_d;

  logic serial_clock_q, serial_clock_d;
  logic serial_data_q, serial_data_d;
  logic serial_load_q, serial_load_d;
  logic serial_resetn_q, serial_resetn_d;
  logic busy_q, busy_d;
  logic done_q, done_d;

  logic ser_load, ser_step, ser_bit, ser_phase, ser_last;

  gpio_cfg_serializer #(
    .N (N)
  ) u_serializer (
    .clk_i     (clock),
    .rst_i     (reset),
    .load_i    (ser_load),
    .step_i    (ser_step),
    .data_i    (cfg_data),
    .bit_out_o (ser_bit),
    .phase_o   (ser_phase),
    .last_o    (ser_last)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q         <= IDLE;
      clr_cnt_q       <= '0;
      serial_clock_q  <= 1'b0;
      serial_data_q   <= 1'b0;
      serial_load_q   <= 1'b0;
      serial_resetn_q <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      clr_cnt_q       <= clr_cnt_d;
      serial_clock_q  <= serial_clock_d;
      serial_data_q   <= serial_data_d;
      serial_load_q   <= serial_load_d;
      serial_resetn_q <= serial_resetn_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
    end
  end

  // SHIFT ends once phase B of bit 0 is on the chain (serial clock high).
  always_comb begin
    state_d  = state_q;
    ser_load = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d  = CLEAR;
          ser_load = 1'b1;
        end
      end
      CLEAR: begin
        if (clr_cnt_q == CLEAR_CNT_W'(CLEAR_CYCLES - 1)) begin
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (ser_last && serial_clock_q) begin
          state_d = LOAD;
        end
      end
      LOAD:    state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  // Output registers are loaded with the values belonging to the next state.
  always_comb begin
    ser_step        = (state_d == SHIFT);
    clr_cnt_d       = ((state_q == CLEAR) && (state_d == CLEAR)) ?
                      clr_cnt_q + CLEAR_CNT_W'(1) : '0;
    serial_clock_d  = 1'b0;
    serial_data_d   = 1'b0;
    serial_load_d   = 1'b0;
    serial_resetn_d = 1'b1;
    busy_d          = 1'b0;
    done_d          = 1'b0;
    case (state_d)
      CLEAR: begin
        serial_resetn_d = 1'b0;
        busy_d          = 1'b1;
      end
      SHIFT: begin
        busy_d         = 1'b1;
        serial_clock_d = ser_phase;
        serial_data_d  = ser_bit;
      end
      LOAD: begin
        busy_d        = 1'b1;
        serial_load_d = 1'b1;
      end
      DONE:    done_d = 1'b1;
      default: ;
    endcase
  end

  assign serial_clock    = serial_clock_q;
  assign serial_data_out = serial_data_q;
  assign serial_load     = serial_load_q;
  assign serial_resetn   = serial_resetn_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign dbg_state       = state_q;

endmodule
